// File: rtl/update_scheduler.sv
// update_scheduler: takes rate-edge updates from the host through a valid/ready handshake
// and buffers them in a circular FIFO. It then issues one Container run per update: it holds
// u_src/u_dst/u_e, pulses container_reset for one cycle, and waits for container_done.
// Optional feature: define UPDATE_SCHEDULER_COALESCE_EN to merge a new update into a queued
// entry that has the same (src,dst) pair.
module update_scheduler #(
    parameter int VERT_BITS   = 6,
    parameter int WEIGHT_BITS = 32,
    parameter int DEPTH       = 8
) (
    input  logic                     clk,
    input  logic                     sched_reset_n,
    input  logic                     upd_valid,
    output logic                     upd_ready,
    input  logic [VERT_BITS-1:0]     upd_src,
    input  logic [VERT_BITS-1:0]     upd_dst,
    input  logic [WEIGHT_BITS-1:0]   upd_e,
    output logic [VERT_BITS-1:0]     u_src,
    output logic [VERT_BITS-1:0]     u_dst,
    output logic [WEIGHT_BITS-1:0]   u_e,
    output logic                     container_reset,
    input  logic                     container_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              run_count,
    output logic [7:0]               drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_KICK = 2'd1, S_WAIT = 2'd2} state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [VERT_BITS-1:0]   u_src_q, u_src_d, u_dst_q, u_dst_d;
    logic [WEIGHT_BITS-1:0] u_e_q, u_e_d;
    logic [15:0]            run_q, run_d;
    logic [7:0]             drop_q, drop_d;

    logic [VERT_BITS-1:0]   mem_src [DEPTH];
    logic [VERT_BITS-1:0]   mem_dst [DEPTH];
    logic [WEIGHT_BITS-1:0] mem_e   [DEPTH];

    logic push_acc, self_loop, pop, coal_hit, coal_wr, enq;

    // Saturating increment for the 8-bit drop counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign push_acc  = upd_valid & upd_ready;
    assign self_loop = (upd_src == upd_dst);
    assign pop       = (state_q == S_IDLE) && (count_q != '0);

`ifdef UPDATE_SCHEDULER_COALESCE_EN
    logic [AW-1:0] coal_idx;

    // Find the oldest queued entry with the same endpoints; the head is skipped while it is popped.
    always_comb begin
        logic [AW-1:0] idx;
        idx      = '0;
        coal_hit = 1'b0;
        coal_idx = rd_ptr_q;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            idx = rd_ptr_q + AW'(k);
            if ((CW'(k) < count_q) && !((k == 0) && pop) &&
                (mem_src[idx] == upd_src) && (mem_dst[idx] == upd_dst)) begin
                coal_hit = 1'b1;
                coal_idx = idx;
            end
        end
    end
`else
    assign coal_hit = 1'b0;
`endif

    assign coal_wr = push_acc & ~self_loop & coal_hit;
    assign enq     = push_acc & ~self_loop & ~coal_hit;

    // FIFO storage: written on enqueue (and on a coalescing weight overwrite); not reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_src[wr_ptr_q] <= upd_src;
            mem_dst[wr_ptr_q] <= upd_dst;
            mem_e[wr_ptr_q]   <= upd_e;
        end
`ifdef UPDATE_SCHEDULER_COALESCE_EN
        if (coal_wr) begin
            mem_e[coal_idx] <= upd_e;
        end
`endif
    end

    // Next-state for pointers, count, hold registers and the statistics counters.
    always_comb begin
        wr_ptr_d = enq ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({enq, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        u_src_d = u_src_q;
        u_dst_d = u_dst_q;
        u_e_d   = u_e_q;
        if (pop) begin
            u_src_d = mem_src[rd_ptr_q];
            u_dst_d = mem_dst[rd_ptr_q];
            u_e_d   = mem_e[rd_ptr_q];
        end
        run_d  = (state_q == S_WAIT && container_done) ? run_q + 16'd1 : run_q;
        drop_d = (push_acc && self_loop) ? sat_inc8(drop_q) : drop_q;
    end

    // Control and hold registers; a reset abandons any run in flight and empties the FIFO.
    always_ff @(posedge clk or negedge sched_reset_n) begin
        if (!sched_reset_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            u_src_q  <= '0;
            u_dst_q  <= '0;
            u_e_q    <= '0;
            run_q    <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            u_src_q  <= u_src_d;
            u_dst_q  <= u_dst_d;
            u_e_q    <= u_e_d;
            run_q    <= run_d;
            drop_q   <= drop_d;
        end
    end

    // Run sequencing: pop in IDLE, one-cycle kick, then wait for the Container to finish.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (count_q != '0) state_d = S_KICK;
            S_KICK:  state_d = S_WAIT;
            S_WAIT:  if (container_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        container_reset = (state_q == S_KICK);
        busy            = (state_q == S_KICK) || (state_q == S_WAIT);
    end

    // Ready follows the registered count only, and is held low while reset is asserted.
    assign upd_ready  = sched_reset_n & (count_q != FULL);
    assign u_src      = u_src_q;
    assign u_dst      = u_dst_q;
    assign u_e        = u_e_q;
    assign fifo_count = count_q;
    assign run_count  = run_q;
    assign drop_count = drop_q;
endmodule
